// File: rtl/prbs_pkg.sv
// rtl/prbs_pkg.sv - PRBS-31 (x^31+x^28+1) constants, state type and next-state function.
package prbs_pkg;

   localparam int PRBS_LEN = 31;
   localparam int PRBS_TAP = 3;

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } chk_state_t;

   // Upper bits use the old state; the low TAP bits fold in the freshly computed top bits.
   function automatic logic [PRBS_LEN-1:0] prbs31_next(input logic [PRBS_LEN-1:0] s);
      logic [PRBS_LEN-1:0] f;
      f[PRBS_LEN-1:PRBS_TAP] = s[PRBS_LEN-1:PRBS_TAP] ^ s[PRBS_LEN-1-PRBS_TAP:0];
      f[PRBS_TAP-1:0]        = s[PRBS_TAP-1:0] ^ f[PRBS_LEN-1:PRBS_LEN-PRBS_TAP];
      return f;
   endfunction

endpackage

// File: rtl/prbs_check_popcount31.sv
// rtl/prbs_check_popcount31.sv - combinational population count of a 31-bit error mask.
module popcount31 (
   input  logic [30:0] din,
   output logic [4:0]  cnt
);

   always_comb begin
      cnt = '0;
      for (int i = 0; i < 31; i++) begin
         cnt = cnt + {4'd0, din[i]};
      end
   end

endmodule

// File: rtl/prbs_check.sv
// rtl/prbs_check.sv - self-synchronising PRBS-31 checker with lock FSM and saturating error counters.
module prbs_check
   import prbs_pkg::*;
#(
   parameter int WIDTH      = 31,
   parameter int CNT_W      = 32,
   parameter int LOCK_CNT   = 16,
   parameter int UNLOCK_CNT = 4
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [WIDTH-1:0] di,
   input  logic             valid,
   input  logic             clear_cnt,
   output logic             locked,
   output logic             err,
   output logic [CNT_W-1:0] err_bits,
   output logic [CNT_W-1:0] err_words
);

   if (WIDTH != PRBS_LEN) begin : g_bad_width
      $error("prbs_check: WIDTH must be 31");
   end
   if (LOCK_CNT < 1 || LOCK_CNT > 255) begin : g_bad_lock
      $error("prbs_check: LOCK_CNT must be 1..255");
   end
   if (UNLOCK_CNT < 1 || UNLOCK_CNT > 255) begin : g_bad_unlock
      $error("prbs_check: UNLOCK_CNT must be 1..255");
   end
   if (CNT_W < 1) begin : g_bad_cnt
      $error("prbs_check: CNT_W must be at least 1");
   end

   localparam int                  SUM_W       = ((CNT_W > 5) ? CNT_W : 5) + 1;
   localparam logic [7:0]          GOOD_TGT    = 8'(LOCK_CNT);
   localparam logic [7:0]          BAD_TGT     = 8'(UNLOCK_CNT);
   localparam logic [CNT_W-1:0]    CNT_MAX     = '1;
   localparam logic [SUM_W-1:0]    CNT_MAX_EXT = SUM_W'(CNT_MAX);
   localparam logic [PRBS_LEN-1:0] ALL_ONES    = '1;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   chk_state_t           state_q, state_d;
   logic [PRBS_LEN-1:0]  ref_q, ref_d;
   logic [7:0]           good_q, good_d;
   logic [7:0]           bad_q, bad_d;
   logic                 locked_q, locked_d;
   logic                 err_q, err_d;
   logic [CNT_W-1:0]     err_bits_q, err_bits_d;
   logic [CNT_W-1:0]     err_words_q, err_words_d;

   logic [PRBS_LEN-1:0]  di_w;
   logic [PRBS_LEN-1:0]  next_ref;
   logic [PRBS_LEN-1:0]  err_mask;
   logic                 mismatch;
   logic                 count_word;
   logic [4:0]           pop_cnt;
   logic [SUM_W-1:0]     bits_sum;

   assign di_w     = di[PRBS_LEN-1:0];
   assign next_ref = prbs31_next(ref_q);
   assign err_mask = di_w ^ ~next_ref;
   assign mismatch = |err_mask;

   popcount31 u_popcount (
      .din (err_mask),
      .cnt (pop_cnt)
   );

   always_comb begin
      state_d    = state_q;
      ref_d      = ref_q;
      good_d     = good_q;
      bad_d      = bad_q;
      err_d      = 1'b0;
      count_word = 1'b0;
      if (valid) begin
         unique case (state_q)
            SEARCH: begin
               // An all-ones word would seed a zero reference, which is a dead LFSR state.
               if (di_w != ALL_ONES) begin
                  ref_d   = ~di_w;
                  good_d  = '0;
                  state_d = VERIFY;
               end
            end
            VERIFY: begin
               if (!mismatch) begin
                  ref_d  = next_ref;
                  good_d = sat_inc8(good_q);
                  if (good_d == GOOD_TGT) begin
                     state_d = LOCKED;
                     bad_d   = '0;
                  end
               end else begin
                  good_d = '0;
                  if (di_w == ALL_ONES) state_d = SEARCH;
                  else                  ref_d   = ~di_w;
               end
            end
            LOCKED: begin
               // Flywheel: the reference keeps running so isolated errors never disturb alignment.
               ref_d = next_ref;
               if (mismatch) begin
                  err_d      = 1'b1;
                  count_word = 1'b1;
                  bad_d      = sat_inc8(bad_q);
                  if (bad_d == BAD_TGT) state_d = SEARCH;
               end else begin
                  bad_d = '0;
               end
            end
            default: state_d = SEARCH;
         endcase
      end
   end

   always_comb begin
      err_words_d = err_words_q;
      err_bits_d  = err_bits_q;
      bits_sum    = SUM_W'(err_bits_q) + SUM_W'(pop_cnt);
      if (clear_cnt) begin
         err_words_d = '0;
         err_bits_d  = '0;
      end else if (count_word) begin
         if (err_words_q != CNT_MAX) err_words_d = err_words_q + CNT_W'(1);
         err_bits_d = (bits_sum > CNT_MAX_EXT) ? CNT_MAX : bits_sum[CNT_W-1:0];
      end
      locked_d = (state_d == LOCKED);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= SEARCH;
         ref_q       <= '0;
         good_q      <= '0;
         bad_q       <= '0;
         locked_q    <= 1'b0;
         err_q       <= 1'b0;
         err_bits_q  <= '0;
         err_words_q <= '0;
      end else begin
         state_q     <= state_d;
         ref_q       <= ref_d;
         good_q      <= good_d;
         bad_q       <= bad_d;
         locked_q    <= locked_d;
         err_q       <= err_d;
         err_bits_q  <= err_bits_d;
         err_words_q <= err_words_d;
      end
   end

   assign locked    = locked_q;
   assign err       = err_q;
   assign err_bits  = err_bits_q;
   assign err_words = err_words_q;

endmodule
